// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the program-counter stage.
// Cause codes, next-PC select and exception-level state encodings.
package pc_ctrl_pkg;

   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_OV   = 5'd12;

   typedef enum logic [2:0] {
      SEL_SEQ  = 3'd0,
      SEL_BR   = 3'd1,
      SEL_J    = 3'd2,
      SEL_JR   = 3'd3,
      SEL_TRAP = 3'd4,
      SEL_ERET = 3'd5
   } pc_sel_e;

   typedef enum logic {
      ST_NORMAL  = 1'b0,
      ST_HANDLER = 1'b1
   } exl_state_e;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC target arithmetic derived from the current PC.
// All additions wrap modulo 2^32.
module pc_target_calc (
   input  logic [31:0] pc,
   input  logic [15:0] imm16,
   input  logic [25:0] jtarget,
   output logic [31:0] pc_plus4,
   output logic [31:0] br_target,
   output logic [31:0] j_target
);

   logic [31:0] br_offset;

   always_comb begin
      pc_plus4  = pc + 32'd4;
      br_offset = {{14{imm16[15]}}, imm16, 2'b00};
      br_target = pc_plus4 + br_offset;
      j_target  = {pc_plus4[31:28], jtarget, 2'b00};
   end

endmodule

// File: rtl/pc_ctrl.sv
// Program counter, EPC and exception-level state for the single-cycle core.
// Resolves branches, jumps, traps and eret into the next fetch address.
module pc_ctrl
   import pc_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        branch_eq,
   input  logic        branch_ne,
   input  logic        jump,
   input  logic        jump_reg,
   input  logic        eret,
   input  logic        ovf_trap_en,
   input  logic [15:0] imm16,
   input  logic [25:0] jtarget,
   input  logic [31:0] rs_data,
   input  logic        alu_zero,
   input  logic        alu_overflow,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] epc,
   output logic        exl,
   output logic [4:0]  cause,
   output logic        exc_taken
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] epc_q, epc_d;
   logic [4:0]  cause_q, cause_d;
   logic        exc_taken_q, exc_taken_d;
   exl_state_e  state_q, state_d;

   logic [31:0] br_target;
   logic [31:0] j_target;
   logic        ovf_trap;
   logic        adel_trap;
   logic        br_taken;
   pc_sel_e     sel;

   pc_target_calc u_target (
      .pc        (pc_q),
      .imm16     (imm16),
      .jtarget   (jtarget),
      .pc_plus4  (pc_plus4),
      .br_target (br_target),
      .j_target  (j_target)
   );

   always_comb begin
      ovf_trap  = ovf_trap_en & alu_overflow;
      adel_trap = jump_reg & (rs_data[1:0] != 2'b00);
      br_taken  = (branch_eq & alu_zero) | (branch_ne & ~alu_zero);
      // eret outside the handler degrades to a plain sequential step
      if (ovf_trap || adel_trap)             sel = SEL_TRAP;
      else if (eret && state_q == ST_HANDLER) sel = SEL_ERET;
      else if (eret)                         sel = SEL_SEQ;
      else if (jump_reg)                     sel = SEL_JR;
      else if (jump)                         sel = SEL_J;
      else if (br_taken)                     sel = SEL_BR;
      else                                   sel = SEL_SEQ;
   end

   always_comb begin
      pc_d        = pc_q;
      epc_d       = epc_q;
      cause_d     = cause_q;
      exc_taken_d = exc_taken_q;
      state_d     = state_q;
      if (en) begin
         exc_taken_d = 1'b0;
         case (sel)
            SEL_TRAP: begin
               pc_d        = EXC_VECTOR;
               cause_d     = ovf_trap ? EXC_OV : EXC_ADEL;
               exc_taken_d = 1'b1;
               state_d     = ST_HANDLER;
               // a nested trap must not clobber the original return address
               if (state_q == ST_NORMAL) epc_d = pc_q;
            end
            SEL_ERET: begin
               pc_d    = epc_q;
               state_d = ST_NORMAL;
            end
            SEL_JR:  pc_d = rs_data;
            SEL_J:   pc_d = j_target;
            SEL_BR:  pc_d = br_target;
            default: pc_d = pc_plus4;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q        <= RESET_PC;
         epc_q       <= 32'h0;
         cause_q     <= 5'd0;
         exc_taken_q <= 1'b0;
         state_q     <= ST_NORMAL;
      end else begin
         pc_q        <= pc_d;
         epc_q       <= epc_d;
         cause_q     <= cause_d;
         exc_taken_q <= exc_taken_d;
         state_q     <= state_d;
      end
   end

   assign pc        = pc_q;
   assign epc       = epc_q;
   assign cause     = cause_q;
   assign exc_taken = exc_taken_q;
   assign exl       = (state_q == ST_HANDLER);

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed vector table then random
// stimulus compared against a behavioural model of the next-PC rules.
module tb_pc_ctrl;

   localparam logic [31:0] EXC_V = 32'h8000_0180;

   logic        clk = 1'b0;
   logic        rst, en, branch_eq, branch_ne, jump, jump_reg, eret;
   logic        ovf_trap_en, alu_zero, alu_overflow;
   logic [15:0] imm16;
   logic [25:0] jtarget;
   logic [31:0] rs_data;
   logic [31:0] pc, pc_plus4, epc;
   logic        exl, exc_taken;
   logic [4:0]  cause;

   int checks = 0;
   int failures = 0;

   pc_ctrl dut (
      .clk(clk), .rst(rst), .en(en),
      .branch_eq(branch_eq), .branch_ne(branch_ne),
      .jump(jump), .jump_reg(jump_reg), .eret(eret),
      .ovf_trap_en(ovf_trap_en), .imm16(imm16),
      .jtarget(jtarget), .rs_data(rs_data),
      .alu_zero(alu_zero), .alu_overflow(alu_overflow),
      .pc(pc), .pc_plus4(pc_plus4), .epc(epc), .exl(exl),
      .cause(cause), .exc_taken(exc_taken)
   );

   always #5 clk = ~clk;

   // controls packed as {rst,en,beq,bne,j,jr,eret,ovf_en,ovf,zero}
   typedef struct {
      logic [9:0]  ctl;
      logic [15:0] imm;
      logic [25:0] jt;
      logic [31:0] rs;
      logic [31:0] e_pc;
      logic [31:0] e_epc;
      logic        e_exl;
      logic [4:0]  e_cause;
      logic        e_exc;
   } vec_t;

   vec_t vecs[$];

   // model state
   logic [31:0] m_pc, m_epc;
   logic        m_exl, m_exc;
   logic [4:0]  m_cause;

   function automatic vec_t mk(logic [9:0] c, logic [15:0] i,
                               logic [25:0] t, logic [31:0] r,
                               logic [31:0] p, logic [31:0] e,
                               logic x, logic [4:0] ca, logic ex);
      vec_t v;
      v.ctl = c; v.imm = i; v.jt = t; v.rs = r;
      v.e_pc = p; v.e_epc = e; v.e_exl = x;
      v.e_cause = ca; v.e_exc = ex;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(logic [9:0] c, logic [15:0] i,
                        logic [25:0] t, logic [31:0] r);
      {rst, en, branch_eq, branch_ne, jump, jump_reg,
       eret, ovf_trap_en, alu_overflow, alu_zero} = c;
      imm16 = i; jtarget = t; rs_data = r;
   endtask

   task automatic check_all(string tag, logic [31:0] p, logic [31:0] e,
                            logic x, logic [4:0] ca, logic ex);
      chk({tag, ".pc"}, pc, p);
      chk({tag, ".pc_plus4"}, pc_plus4, p + 32'd4);
      chk({tag, ".epc"}, epc, e);
      chk({tag, ".exl"}, {31'd0, exl}, {31'd0, x});
      chk({tag, ".cause"}, {27'd0, cause}, {27'd0, ca});
      chk({tag, ".exc_taken"}, {31'd0, exc_taken}, {31'd0, ex});
   endtask

   // Behavioural reference: one architectural step from the rules.
   task automatic model_step();
      logic [31:0] p4;
      logic ovf, adel, taken;
      if (rst) begin
         m_pc = 0; m_epc = 0; m_exl = 0; m_cause = 0; m_exc = 0;
      end else if (en) begin
         p4    = m_pc + 4;
         ovf   = ovf_trap_en && alu_overflow;
         adel  = jump_reg && (rs_data % 4 != 0);
         taken = (branch_eq && alu_zero) || (branch_ne && !alu_zero);
         if (ovf || adel) begin
            if (!m_exl) m_epc = m_pc;
            m_cause = ovf ? 5'd12 : 5'd4;
            m_exl = 1; m_exc = 1; m_pc = EXC_V;
         end else begin
            m_exc = 0;
            if (eret && m_exl) begin
               m_pc = m_epc; m_exl = 0;
            end else if (eret)  m_pc = p4;
            else if (jump_reg)  m_pc = rs_data;
            else if (jump)      m_pc = {p4[31:28], jtarget, 2'b00};
            else if (taken)     m_pc = p4 + 32'($signed(imm16)) * 4;
            else                m_pc = p4;
         end
      end
   endtask

   localparam logic [9:0] RST  = 10'b1000000000;
   localparam logic [9:0] SEQ  = 10'b0100000000;
   localparam logic [9:0] HOLD = 10'b0000000000;
   localparam logic [9:0] JR   = 10'b0100010000;
   localparam logic [9:0] J    = 10'b0100100000;
   localparam logic [9:0] BEQZ = 10'b0110000001;
   localparam logic [9:0] BEQN = 10'b0110000000;
   localparam logic [9:0] ERET = 10'b0100001000;
   localparam logic [9:0] OVJ  = 10'b0100100110;
   localparam logic [9:0] OV   = 10'b0100000110;
   localparam logic [9:0] ROV  = 10'b1100000110;
   localparam logic [9:0] HOV  = 10'b0000000110;
   localparam logic [9:0] BOTH = 10'b0111000000;

   initial begin
      drive(RST, 0, 0, 0);

      vecs.push_back(mk(RST,  0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(SEQ,  0, 0, 0, 4, 0, 0, 0, 0));
      vecs.push_back(mk(SEQ,  0, 0, 0, 8, 0, 0, 0, 0));
      vecs.push_back(mk(SEQ,  0, 0, 0, 12, 0, 0, 0, 0));
      vecs.push_back(mk(HOLD, 0, 0, 0, 12, 0, 0, 0, 0));
      vecs.push_back(mk(HOLD, 0, 0, 0, 12, 0, 0, 0, 0));
      vecs.push_back(mk(JR, 0, 0, 32'h100, 32'h100, 0, 0, 0, 0));
      vecs.push_back(mk(BEQZ, 16'hFFFC, 0, 0, 32'hF4, 0, 0, 0, 0));
      vecs.push_back(mk(JR, 0, 0, 32'h100, 32'h100, 0, 0, 0, 0));
      vecs.push_back(mk(BEQN, 16'hFFFC, 0, 0, 32'h104, 0, 0, 0, 0));
      vecs.push_back(mk(JR, 0, 0, 32'h1000_0010, 32'h1000_0010,
                        0, 0, 0, 0));
      vecs.push_back(mk(J, 0, 26'h40, 0, 32'h1000_0100, 0, 0, 0, 0));
      vecs.push_back(mk(JR, 0, 0, 32'h2002, EXC_V,
                        32'h1000_0100, 1, 4, 1));
      vecs.push_back(mk(SEQ, 0, 0, 0, 32'h8000_0184,
                        32'h1000_0100, 1, 4, 0));
      vecs.push_back(mk(ERET, 0, 0, 0, 32'h1000_0100,
                        32'h1000_0100, 0, 4, 0));
      vecs.push_back(mk(JR, 0, 0, 32'h200, 32'h200,
                        32'h1000_0100, 0, 4, 0));
      vecs.push_back(mk(OVJ, 0, 26'h123, 0, EXC_V, 32'h200, 1, 12, 1));
      vecs.push_back(mk(SEQ, 0, 0, 0, 32'h8000_0184, 32'h200, 1, 12, 0));
      vecs.push_back(mk(OV, 0, 0, 0, EXC_V, 32'h200, 1, 12, 1));
      vecs.push_back(mk(ERET, 0, 0, 0, 32'h200, 32'h200, 0, 12, 0));
      vecs.push_back(mk(ERET, 0, 0, 0, 32'h204, 32'h200, 0, 12, 0));
      vecs.push_back(mk(OV, 0, 0, 0, EXC_V, 32'h204, 1, 12, 1));
      vecs.push_back(mk(ROV, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(JR, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC,
                        0, 0, 0, 0));
      vecs.push_back(mk(SEQ, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(HOV, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(BOTH, 16'h0001, 0, 0, 8, 0, 0, 0, 0));
      vecs.push_back(mk(OV, 0, 0, 0, EXC_V, 8, 1, 12, 1));
      vecs.push_back(mk(HOLD, 0, 0, 0, EXC_V, 8, 1, 12, 1));
      vecs.push_back(mk(SEQ, 0, 0, 0, 32'h8000_0184, 8, 1, 12, 0));

      foreach (vecs[k]) begin
         @(negedge clk);
         drive(vecs[k].ctl, vecs[k].imm, vecs[k].jt, vecs[k].rs);
         @(posedge clk);
         #1;
         check_all($sformatf("vec%0d", k), vecs[k].e_pc, vecs[k].e_epc,
                   vecs[k].e_exl, vecs[k].e_cause, vecs[k].e_exc);
      end

      // random phase against the model
      @(negedge clk);
      drive(RST, 0, 0, 0);
      model_step();
      @(posedge clk);
      #1;
      check_all("rnd_rst", m_pc, m_epc, m_exl, m_cause, m_exc);
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         rst          = ($urandom_range(0, 99) == 0);
         en           = ($urandom_range(0, 5) != 0);
         branch_eq    = ($urandom_range(0, 3) == 0);
         branch_ne    = ($urandom_range(0, 3) == 0);
         jump         = ($urandom_range(0, 7) == 0);
         jump_reg     = ($urandom_range(0, 9) == 0);
         eret         = ($urandom_range(0, 9) == 0);
         ovf_trap_en  = ($urandom_range(0, 3) == 0);
         alu_overflow = ($urandom_range(0, 4) == 0);
         alu_zero     = 1'($urandom);
         imm16        = 16'($urandom);
         jtarget      = 26'($urandom);
         rs_data      = $urandom;
         if ($urandom_range(0, 3) != 0) rs_data[1:0] = 2'b00;
         model_step();
         @(posedge clk);
         #1;
         check_all($sformatf("rnd%0d", n), m_pc, m_epc, m_exl,
                   m_cause, m_exc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Program-counter and next-PC stage for the single-cycle datapath. It sits directly downstream of the 32-bit ALU and consumes the ALU's Zero and Overflow flags to resolve conditional branches and signed-overflow traps. It holds the architectural PC, EPC and exception state, and drives the instruction-fetch address for the next cycle.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- EXC_VECTOR, 32'h8000_0180, trap handler address

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  synchronous, active-high reset
- en  in  1  1 = commit this cycle's instruction; 0 = hold all state
- branch_eq  in  1  BEQ: taken when alu_zero=1
- branch_ne  in  1  BNE: taken when alu_zero=0
- jump  in  1  J/JAL
- jump_reg  in  1  JR; target is rs_data
- eret  in  1  return from exception
- ovf_trap_en  in  1  current instruction is a trapping ADD/SUB
- imm16  in  16  branch offset in words, signed
- jtarget  in  26  jump index
- rs_data  in  32  register operand for JR
- alu_zero  in  1  ALU Zero flag
- alu_overflow  in  1  ALU Overflow flag
- pc  out  32  current fetch address (registered)
- pc_plus4  out  32  pc + 4 (combinational)
- epc  out  32  exception PC (registered)
- exl  out  1  exception level; 1 while in handler
- cause  out  5  last exception code (registered)
- exc_taken  out  1  one-cycle pulse; high during the first cycle at EXC_VECTOR

## Operation
- The next-PC source is chosen at each rising edge with en=1. Priority, highest first: trap, eret, jump_reg, jump, taken branch, sequential.
- Overflow trap: ovf_trap_en & alu_overflow.
  - cause <= 12, pc <= EXC_VECTOR, exl <= 1, exc_taken <= 1.
  - epc <= pc only if exl was 0. A nested trap keeps the existing epc.
- Alignment trap: jump_reg with rs_data[1:0] != 0.
  - cause <= 4. Otherwise handled exactly like the overflow trap.
  - If both trap conditions hold in the same cycle, overflow wins (cause=12).
- eret with exl=1: pc <= epc, exl <= 0. eret with exl=0 acts as a sequential instruction (pc <= pc+4).
- Branch target: pc_plus4 + (sign-extended imm16 << 2), modulo 2^32; wrap-around is silent.
- Jump target: {pc_plus4[31:28], jtarget, 2'b00}.
- Sequential: pc <= pc_plus4. 32'hFFFF_FFFC wraps to 0.
- If both branch_eq and branch_ne are asserted, the branch is taken if either condition is met.
- State machine on exl:
  - NORMAL (exl=0) goes to HANDLER on any trap.
  - HANDLER (exl=1) goes to NORMAL on eret. A trap in HANDLER stays in HANDLER.
- exc_taken is cleared on the next en=1 edge unless a new trap is taken. It holds its value while en=0.

## Timing
- Reset (rst=1 at a rising edge, regardless of en) sets pc=RESET_PC, epc=0, exl=0, cause=0, exc_taken=0.
- Reset asserted mid-trap or mid-handler discards all pending state.
- Latency: the flags and controls of the instruction at pc are sampled at the edge; the new pc is visible one clock later. Zero bubble cycles.
- en=0: pc, epc, exl, cause and exc_taken all hold. Flags presented during en=0 are ignored.
- pc_plus4 and all target arithmetic are combinational from pc. No other combinational path from inputs to outputs.

## Structure
- Shared package holds:
  - cause codes EXC_ADEL=5'd4 and EXC_OV=5'd12
  - next-PC select enum: SEL_SEQ, SEL_BR, SEL_J, SEL_JR, SEL_TRAP, SEL_ERET
- One combinational sub-module, pc_target_calc: computes the branch and jump targets and pc_plus4 from pc, imm16 and jtarget.
- Select logic and registers stay in pc_ctrl.

## Test plan
- Reset, then 3 edges with en=1 and no controls → pc = 0, 4, 8, 12. Hold en=0 for 2 edges → pc stays 12.
- pc=0x100, branch_eq=1, alu_zero=1, imm16=16'hFFFC → pc=0xF4. Same with alu_zero=0 → pc=0x104.
- pc=0x1000_0010, jump=1, jtarget=26'h40 → pc=0x1000_0100. Then jump_reg=1, rs_data=0x2002 → trap: pc=0x8000_0180, cause=4, epc=0x1000_0100, exc_taken high for exactly 1 cycle.
- pc=0x200, ovf_trap_en=1, alu_overflow=1 with jump=1 also asserted → pc=EXC_VECTOR, epc=0x200, cause=12, exl=1. Then eret → pc=0x200, exl=0.
- Nested trap while exl=1 at pc=0x8000_0184 → epc stays 0x200. eret with exl=0 → pc advances by 4.
- rst asserted during the exc_taken cycle → all outputs return to reset values on the same edge. pc=0xFFFF_FFFC with sequential advance → pc=0.
